fetch_ctrl: RTL and testbench

// - Parametrised fetch/sequencing unit: next generation of the halt_handler + instr_fetch + decoder trio.
// - Owns the program counter and drives instr_addr to an asynchronous-read instruction memory.
// - Registers each fetched instruction and splits it into opcode/Rm/Rn/jump_addr for the execute stage.
// - Adds what the old trio lacked: reset, jump and halt handled in one FSM, a button-driven resume, and an optional single-step.

---
 rtl/fetch_ctrl.sv | 77 +++++++
 tb/tb_fetch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC/fetch/decode sequencer with halt, button resume and optional single-step.
// Define FETCH_STEP_EN to add the step_btn port and single-step fetch while halted.
module fetch_ctrl #(
  parameter int OPC_W = 4,
  parameter int REG_W = 6,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF,
  parameter logic [OPC_W-1:0] JUMP_OPC = 4'h2,
  localparam int INSTR_W = OPC_W + 2*REG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic resume_btn,
`ifdef FETCH_STEP_EN
  input  logic step_btn,
`endif
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [OPC_W-1:0] opcode,
  output logic [REG_W-1:0] Rm,
  output logic [REG_W-1:0] Rn,
  output logic [ADDR_W-1:0] jump_addr,
  output logic instr_valid,
  output logic halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [OPC_W-1:0] cur_opc;
  logic [2:0] res_sync;
  logic res_edge, step_edge, fetch;
  assign cur_opc = instr[INSTR_W-1 -: OPC_W];
  // two synchroniser flops followed by the previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) res_sync <= '0;
    else res_sync <= {res_sync[1:0], resume_btn};
  assign res_edge = res_sync[1] & ~res_sync[2];
`ifdef FETCH_STEP_EN
  logic [2:0] step_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) step_sync <= '0;
    else step_sync <= {step_sync[1:0], step_btn};
  assign step_edge = step_sync[1] & ~step_sync[2];
`else
  assign step_edge = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_nx;
  // a resume edge outranks a step edge while halted
  always_comb begin
    fetch = (state == RUN) | (~res_edge & step_edge);
    state_nx = (state == RUN) ? ((cur_opc == HALT_OPC) ? HALTED : RUN)
                              : (res_edge ? RUN : HALTED);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      opcode <= '0;
      Rm <= '0;
      Rn <= '0;
      jump_addr <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch;
      if (fetch) begin
        pc <= (cur_opc == JUMP_OPC) ? instr[ADDR_W-1:0] : pc + ADDR_W'(1);
        opcode <= cur_opc;
        Rm <= instr[2*REG_W-1 -: REG_W];
        Rn <= instr[REG_W-1:0];
        jump_addr <= instr[ADDR_W-1:0];
      end
    end
  assign instr_addr = pc;
  assign halted = (state == HALTED);
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of fetch_ctrl against a cycle-level reference model.
module tb_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b1, resume_btn = 1'b0;
`ifdef FETCH_STEP_EN
  logic step_btn = 1'b0;
`endif
  logic [15:0] instr;
  logic [11:0] instr_addr, jump_addr;
  logic [3:0] opcode;
  logic [5:0] Rm, Rn;
  logic instr_valid, halted;
  logic [15:0] mem [4096];
  int tests = 0, failed = 0;
  logic [11:0] m_pc;
  logic [15:0] m_word;
  logic m_valid, m_halt;
  logic [3:0] rhist, shist;
  always #5 clk = ~clk;
  assign instr = mem[instr_addr];
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .resume_btn(resume_btn),
`ifdef FETCH_STEP_EN
    .step_btn(step_btn),
`endif
    .instr(instr), .instr_addr(instr_addr), .opcode(opcode), .Rm(Rm), .Rn(Rn),
    .jump_addr(jump_addr), .instr_valid(instr_valid), .halted(halted)
  );
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = 12'h000;
    m_word = 16'h0000;
    m_valid = 1'b0;
    m_halt = 1'b0;
    rhist = 4'b0;
    shist = 4'b0;
  endtask
  task automatic m_fetch();
    m_word = mem[m_pc];
    m_valid = 1'b1;
    m_pc = (m_word[15:12] == 4'h2) ? m_word[11:0] : m_pc + 12'h001;
  endtask
  // one clock: buttons reach the FSM two edges late and act only on a 0->1 transition
  task automatic tick();
    logic re, se;
    rhist = {rhist[2:0], resume_btn};
`ifdef FETCH_STEP_EN
    shist = {shist[2:0], step_btn};
`endif
    re = rhist[2] & ~rhist[3];
    se = shist[2] & ~shist[3];
    @(posedge clk);
    if (!m_halt) begin
      m_fetch();
      if (m_word[15:12] == 4'hF) m_halt = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (re) m_halt = 1'b0;
      else if (se) m_fetch();
    end
    @(negedge clk);
    check("m_addr", instr_addr, m_pc);
    check("m_opcode", opcode, m_word[15:12]);
    check("m_Rm", Rm, m_word[11:6]);
    check("m_Rn", Rn, m_word[5:0]);
    check("m_jump", jump_addr, m_word[11:0]);
    check("m_valid", instr_valid, m_valid);
    check("m_halted", halted, m_halt);
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
  endtask
  initial begin
    #200000 $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, v;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("rst_addr", instr_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_opcode", opcode, 0);
    repeat (5) tick();
    check("pc5", instr_addr, 12'h005);
    #1 rst = 1'b1;
    #1;
    check("async_addr", instr_addr, 0);
    check("async_valid", instr_valid, 0);
    check("async_halted", halted, 0);
    #1 rst = 1'b0;
    model_reset();
    mem[0] = 16'h1041; mem[1] = 16'h2008; mem[8] = 16'h1000; mem[9] = 16'hF000;
    tick();
    check("seq_addr1", instr_addr, 12'h001);
    check("seq_opc", opcode, 1);
    check("seq_Rm", Rm, 1);
    check("seq_Rn", Rn, 1);
    tick();
    check("seq_addr8", instr_addr, 12'h008);
    check("seq_jump", jump_addr, 12'h008);
    tick();
    check("seq_addr9", instr_addr, 12'h009);
    tick();
    check("halt_valid", instr_valid, 1);
    check("halt_halted", halted, 1);
    check("halt_pc", instr_addr, 12'h00A);
    repeat (2) tick();
    check("hold_valid", instr_valid, 0);
    check("hold_pc", instr_addr, 12'h00A);
    resume_btn = 1'b1;
    repeat (3) tick();
    resume_btn = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_pc", instr_addr, 12'h00A);
    tick();
    check("resume_fetch", instr_addr, 12'h00B);
    mem[14] = 16'hF000;
    resume_btn = 1'b1;
    repeat (4) tick();
    check("held_halt", halted, 1);
    repeat (6) tick();
    check("held_stay", halted, 1);
    check("held_pc", instr_addr, 12'h00F);
    resume_btn = 1'b0;
    repeat (3) tick();
    resume_btn = 1'b1;
    n = 0;
    while (halted && n < 8) begin tick(); n++; end
    check("held_resume", halted, 0);
    resume_btn = 1'b0;
    mem[0] = 16'h2FFF; mem[1] = 16'h1000; mem[3] = 16'h2003; mem[4095] = 16'h1000;
    pulse_reset();
    tick();
    check("wrap_top", instr_addr, 12'hFFF);
    mem[0] = 16'h1000;
    tick();
    check("wrap_zero", instr_addr, 12'h000);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("loop_valid", instr_valid, 1);
      check("loop_addr", instr_addr, 12'h003);
    end
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      resume_btn = ($urandom_range(0, 3) == 0);
`ifdef FETCH_STEP_EN
      step_btn = ($urandom_range(0, 2) == 0);
`endif
      tick();
    end
    resume_btn = 1'b0;
`ifdef FETCH_STEP_EN
    step_btn = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000;
    mem[9] = 16'hF000; mem[10] = 16'h1000; mem[11] = 16'h2003;
    pulse_reset();
    repeat (12) tick();
    check("step_halt_pc", instr_addr, 12'h00A);
    v = 0;
    step_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      step_btn = 1'b0;
      v += int'(instr_valid);
    end
    check("step1_pulses", v, 1);
    check("step1_pc", instr_addr, 12'h00B);
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    repeat (4) tick();
    check("step2_pc", instr_addr, 12'h003);
    check("step2_halted", halted, 1);
    step_btn = 1'b1;
    resume_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    resume_btn = 1'b0;
    repeat (2) tick();
    check("step_res_run", halted, 0);
    check("step_res_pc", instr_addr, 12'h003);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
